// File: rtl/width_narrow_stage.sv
// Buffered narrowing stage: wide stream in, narrow stream out through a 2-entry skid buffer.
// Optional build macro WIDTH_NARROW_SAT_EN stores all-ones instead of the low bits when upper bits are lost.
module width_narrow_stage #(
  parameter int WIDE_W   = 32,
  parameter int NARROW_W = 1,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [WIDE_W-1:0]   in_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [NARROW_W-1:0] out_data_o,
  output logic                out_trunc_o,
  output logic [CNT_W-1:0]    trunc_count_o
);

  typedef enum logic [1:0] {EMPTY, HALF, FULL} state_e;

  state_e              state_q;
  logic                inReady_q;
  logic                outValid_q;
  logic [NARROW_W-1:0] headData_q;
  logic                headTrunc_q;
  logic [NARROW_W-1:0] tailData_q;
  logic                tailTrunc_q;
  logic [CNT_W-1:0]    truncCount_q;
  logic [CNT_W-1:0]    truncCount_d;

  logic                inTrunc;
  logic [NARROW_W-1:0] inNarrow;
  logic                doAccept;
  logic                doRelease;

  if (NARROW_W > WIDE_W || NARROW_W < 1) begin : gBadParams
    $error("width_narrow_stage: NARROW_W must be in 1..WIDE_W");
  end

  // Equal widths have no upper slice, so the flag collapses to a constant.
  if (WIDE_W > NARROW_W) begin : gTrunc
    assign inTrunc = |in_data_i[WIDE_W-1:NARROW_W];
  end else begin : gNoTrunc
    assign inTrunc = 1'b0;
  end

`ifdef WIDTH_NARROW_SAT_EN
  assign inNarrow = inTrunc ? {NARROW_W{1'b1}} : in_data_i[NARROW_W-1:0];
`else
  assign inNarrow = in_data_i[NARROW_W-1:0];
`endif

  assign doAccept  = in_valid_i && inReady_q;
  assign doRelease = outValid_q && out_ready_i;

  always_comb begin
    truncCount_d = truncCount_q;
    if (doAccept && inTrunc && (truncCount_q != {CNT_W{1'b1}})) begin
      truncCount_d = truncCount_q + CNT_W'(1);
    end
  end

  // Ready/valid are registered decodes of the next state, so no combinational path crosses the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      inReady_q   <= 1'b1;
      outValid_q  <= 1'b0;
      headData_q  <= '0;
      headTrunc_q <= 1'b0;
      tailData_q  <= '0;
      tailTrunc_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (doAccept) begin
            headData_q  <= inNarrow;
            headTrunc_q <= inTrunc;
            outValid_q  <= 1'b1;
            state_q     <= HALF;
          end
        end
        HALF: begin
          if (doAccept && doRelease) begin
            headData_q  <= inNarrow;
            headTrunc_q <= inTrunc;
          end else if (doAccept) begin
            tailData_q  <= inNarrow;
            tailTrunc_q <= inTrunc;
            inReady_q   <= 1'b0;
            state_q     <= FULL;
          end else if (doRelease) begin
            outValid_q  <= 1'b0;
            state_q     <= EMPTY;
          end
        end
        FULL: begin
          if (doRelease) begin
            headData_q  <= tailData_q;
            headTrunc_q <= tailTrunc_q;
            inReady_q   <= 1'b1;
            state_q     <= HALF;
          end
        end
        default: begin
          state_q    <= EMPTY;
          inReady_q  <= 1'b1;
          outValid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      truncCount_q <= '0;
    end else begin
      truncCount_q <= truncCount_d;
    end
  end

  assign in_ready_o    = inReady_q;
  assign out_valid_o   = outValid_q;
  assign out_data_o    = headData_q;
  assign out_trunc_o   = headTrunc_q;
  assign trunc_count_o = truncCount_q;

endmodule
